// File: rtl/pw_input_cond.sv
// pw_input_cond: synchronizes and debounces the enter button and latches the character with one strobe per press.
module pw_input_cond #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CHAR_W          = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enter_raw,
    input  logic [CHAR_W-1:0] char_raw,
    output logic              enter_pulse,
    output logic [CHAR_W-1:0] char_out,
    output logic              busy
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              enter_m_q, enter_s_q, pulse_q;
    logic [CHAR_W-1:0] char_m_q, char_s_q, char_ref_q, char_out_q;

    assign enter_pulse = pulse_q;
    assign char_out    = char_out_q;
    assign busy        = state_q != IDLE;

    // Reset lands in RELEASE_WAIT so a button held through reset never strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RELEASE_WAIT;
            cnt_q      <= '0;
            enter_m_q  <= 1'b0;
            enter_s_q  <= 1'b0;
            char_m_q   <= '0;
            char_s_q   <= '0;
            char_ref_q <= '0;
            char_out_q <= '0;
            pulse_q    <= 1'b0;
        end else begin
            enter_m_q <= enter_raw;
            enter_s_q <= enter_m_q;
            char_m_q  <= char_raw;
            char_s_q  <= char_m_q;
            pulse_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enter_s_q) begin
                        state_q    <= PRESS_WAIT;
                        cnt_q      <= CW'(1);
                        char_ref_q <= char_s_q;
                    end
                end
                PRESS_WAIT: begin
                    if (!enter_s_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (char_s_q != char_ref_q) begin
                        char_ref_q <= char_s_q;
                        cnt_q      <= CW'(1);
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= PRESSED;
                        cnt_q      <= '0;
                        pulse_q    <= 1'b1;
                        char_out_q <= char_ref_q;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                PRESSED: begin
                    state_q <= RELEASE_WAIT;
                    cnt_q   <= '0;
                end
                default: begin
                    if (enter_s_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pw_input_cond.sv
// tb_pw_input_cond: directed scenarios checked every cycle against a run-length model of the debounce rules.
module tb_pw_input_cond;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enter_raw = 1'b0;
    logic [7:0] char_raw = 8'h00;
    logic       enter_pulse, busy;
    logic [7:0] char_out;

    int n_cmp = 0, n_err = 0, cyc = 0, pulses = 0, last_pulse_cyc = 0;

    pw_input_cond #(.DEBOUNCE_CYCLES(D), .CHAR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .enter_raw(enter_raw), .char_raw(char_raw),
        .enter_pulse(enter_pulse), .char_out(char_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: 2-cycle sample delay, then a press is a run of D high samples with one
    // character while armed; re-arming needs D low samples after the strobe cycle.
    bit       m_e1, m_e2, armed, skip, exp_pulse;
    bit [7:0] m_c1, m_c2, rc, exp_char;
    int       run, low;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_e1 = 0; m_e2 = 0; m_c1 = 0; m_c2 = 0; armed = 0; skip = 0;
            exp_pulse = 0; exp_char = 0; rc = 0; run = 0; low = 0;
        end else begin
            exp_pulse = 0;
            if (skip) skip = 0;
            else if (armed) begin
                run = m_e2 ? ((run != 0 && m_c2 == rc) ? run + 1 : 1) : 0;
                rc = m_c2;
                if (run == D) begin
                    exp_pulse = 1; exp_char = rc; armed = 0; run = 0; low = 0; skip = 1;
                end
            end else begin
                low = m_e2 ? 0 : low + 1;
                if (low == D) begin armed = 1; low = 0; end
            end
            m_e2 = m_e1; m_e1 = enter_raw;
            m_c2 = m_c1; m_c1 = char_raw;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        check("pulse", int'(enter_pulse), int'(exp_pulse));
        check("char_out", int'(char_out), int'(exp_char));
        check("busy", int'(busy), int'(!(armed && run == 0)));
        if (enter_pulse === 1'b1) begin
            pulses++;
            last_pulse_cyc = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] ch, input int hi, output int pc);
        @(negedge clk);
        char_raw = ch; enter_raw = 1'b1; pc = cyc;
        step(hi);
        enter_raw = 1'b0;
        step(10);
    endtask

    initial begin
        int p0, pc;
        bit seq[7];
        seq = '{1, 1, 0, 1, 1, 1, 0};
        step(3);
        #1;
        check("reset_pulse", int'(enter_pulse), 0);
        check("reset_char", int'(char_out), 0);
        check("reset_busy", int'(busy), 1);
        @(negedge clk); reset_n = 1'b1;
        step(10);
        check("idle_busy", int'(busy), 0);
        check("idle_pulses", pulses, 0);

        p0 = pulses;
        press(8'hA5, 20, pc);
        check("clean_count", pulses - p0, 1);
        check("clean_char", int'(char_out), 8'hA5);
        check("clean_latency", last_pulse_cyc - pc, 6);

        p0 = pulses;
        foreach (seq[i]) begin @(negedge clk); enter_raw = seq[i]; end
        step(10);
        check("bounce_count", pulses - p0, 0);
        press(8'h11, 10, pc);
        check("after_bounce_count", pulses - p0, 1);
        check("after_bounce_char", int'(char_out), 8'h11);

        p0 = pulses;
        @(negedge clk); char_raw = 8'h31; enter_raw = 1'b1; pc = cyc;
        step(2); char_raw = 8'h32;
        step(14); enter_raw = 1'b0;
        step(10);
        check("chg_count", pulses - p0, 1);
        check("chg_char", int'(char_out), 8'h32);
        check("chg_latency", last_pulse_cyc - pc, 8);

        p0 = pulses;
        @(negedge clk); enter_raw = 1'b1;
        #2 reset_n = 1'b0;
        step(2); reset_n = 1'b1;
        step(30); enter_raw = 1'b0;
        step(10);
        check("held_reset_count", pulses - p0, 0);
        press(8'h5A, 10, pc);
        check("held_then_press_count", pulses - p0, 1);
        check("held_then_press_char", int'(char_out), 8'h5A);

        p0 = pulses;
        @(negedge clk); char_raw = 8'h42; enter_raw = 1'b1;
        step(10); enter_raw = 1'b0;
        step(2); enter_raw = 1'b1;
        step(10); enter_raw = 1'b0;
        step(10);
        check("short_gap_count", pulses - p0, 1);
        check("short_gap_char", int'(char_out), 8'h42);

        p0 = pulses;
        @(negedge clk); char_raw = 8'h77; enter_raw = 1'b1;
        step(4);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_pulse", int'(enter_pulse), 0);
        check("midreset_char", int'(char_out), 0);
        check("midreset_busy", int'(busy), 1);
        step(2); reset_n = 1'b1;
        step(15); enter_raw = 1'b0;
        step(10);
        check("midreset_count", pulses - p0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pw_input_cond.md
# pw_input_cond

Input conditioner that sits directly upstream of the password FSM. It synchronizes the raw enter push-button and the 8-bit character switch bus, debounces the button, and issues exactly one single-cycle enter strobe per physical press. The strobe carries a character value that is held stable for the FSM to consume. It runs on the MMCM output clock and is held in reset until the MMCM reports lock.

## Interface
- DEBOUNCE_CYCLES, default 100000: consecutive stable synchronized samples required to accept a press or a release; legal range >= 2.
- CHAR_W, default 8: character bus width.

- clk  in  1  FSM clock (MMCM output)
- reset_n  in  1  asynchronous, active-low reset (MMCM lock); one clock domain only
- enter_raw  in  1  raw, bouncy, asynchronous enter button (active-high)
- char_raw  in  CHAR_W  raw asynchronous character switches
- enter_pulse  out  1  one-cycle strobe per accepted press
- char_out  out  CHAR_W  character captured with the latest enter_pulse; held between strobes
- busy  out  1  high while in PRESS_WAIT, PRESSED or RELEASE_WAIT

## Operation
- Synchronizers:
  - enter_raw passes through 2 flops to give enter_s.
  - char_raw passes through 2 flops per bit to give char_s. The switches are quasi-static, so per-bit synchronization is sufficient.
- Counter cnt: width $clog2(DEBOUNCE_CYCLES+1), saturating, no wrap. It clears on every state transition.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: if enter_s=1, go to PRESS_WAIT with cnt=1 and char_ref<=char_s.
  - PRESS_WAIT:
    - If enter_s=0, return to IDLE (bounce rejected).
    - Else if char_s!=char_ref, set char_ref<=char_s and cnt<=1 (character changed mid-press, so the count restarts).
    - Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED.
    - Else cnt++.
  - PRESSED: lasts exactly one cycle. enter_pulse=1 and char_out<=char_ref, registered on the edge entering PRESSED. Then go to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT:
    - If enter_s=1, cnt<=0.
    - Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE.
    - Else cnt++.
- Reset state is RELEASE_WAIT, not IDLE. A button held across reset deassertion therefore never generates a strobe; the button must first be seen low for DEBOUNCE_CYCLES consecutive cycles.
- Reset values:
  - enter_pulse=0, char_out=0, busy=1 (state RELEASE_WAIT)
  - all synchronizer flops 0, cnt=0, char_ref=0
- Reset asserted mid-operation: all of the above apply immediately and asynchronously. A strobe in flight is lost and is not replayed.

## Timing
- enter_pulse is registered, with exactly one cycle high per press. Back-to-back strobes are impossible; the minimum spacing is 2*DEBOUNCE_CYCLES+1 cycles.
- Latency, press to strobe: enter_s first high in cycle k → enter_pulse high in cycle k+DEBOUNCE_CYCLES, provided enter_s and char_s are stable throughout. Add 2 cycles of synchronizer latency to get from enter_raw.
- char_out changes only on the same edge that raises enter_pulse, and is valid in that cycle. The downstream FSM samples both in the same cycle.
- Release: enter_s low from cycle r with no further bounce → IDLE at cycle r+DEBOUNCE_CYCLES. A press is accepted from then on.
- A bounce of any length shorter than DEBOUNCE_CYCLES in PRESS_WAIT yields no strobe. A bounce in RELEASE_WAIT only delays return to IDLE.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset with enter_raw=0: after reset_n rises and enter_s has been low for 4 cycles, the FSM reaches IDLE. enter_pulse=0 and char_out=0x00 throughout.
- Clean press with char_raw=0xA5 held 20 cycles: exactly one enter_pulse, 4 cycles after enter_s rises, with char_out=0xA5 in that cycle. No further pulse.
- Bouncy press: enter_raw high 2 cycles, low 1 cycle, high 3 cycles, then low. No pulse. A following clean press yields exactly one pulse.
- char_raw changes 0x31→0x32 in the 2nd cycle of PRESS_WAIT while enter is held: the count restarts, and the pulse arrives 4 cycles after char_s changes with char_out=0x32.
- enter_raw held high through reset deassertion for 30 cycles, then released: no pulse. After 4 low cycles, a new press of 0x5A gives one pulse with char_out=0x5A.
- Two presses separated by only 2 low cycles: exactly one pulse. reset_n pulsed low during PRESS_WAIT: enter_pulse and char_out go to 0 immediately and no pulse follows.
